// File: rtl/rv_pkg.sv
// Shared types for the multi-cycle RV32 sequencer.
// Phase encoding, trap codes and the reset instruction.
package rv_pkg;

  typedef enum logic [2:0] {
    RST,
    FETCH,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_IMEM_TO  = 2'b01,
    ERR_DMEM_TO  = 2'b10,
    ERR_MISALIGN = 2'b11
  } err_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/rv_mem_port.sv
// Req/ack holder for one memory port with a wait-cycle watchdog.
// The counter rests at zero whenever the port is idle.
module rv_mem_port #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic ack_i,
  output logic req_o,
  output logic done_o,
  output logic timeout_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!active_i) begin
      cnt_d = '0;
    end else if (!ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // an ack in the last allowed cycle beats the timeout
  assign req_o     = active_i;
  assign done_o    = active_i & ack_i;
  assign timeout_o = active_i & ~ack_i & (cnt_q == LIMIT);

endmodule

// File: rtl/rv_mc_seq.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for the RV32 core.
// Owns PC, IR, MDR, the data-port latches and all write enables.
module rv_mc_seq
  import rv_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               TIMEOUT  = 16,
  parameter int               TO_W     = 8,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [XLEN-1:0]  pc_o,
  output logic [31:0]      ir_o,
  output logic [XLEN-1:0]  mdr_o,
  input  logic [XLEN-1:0]  npc_i,
  input  logic [XLEN-1:0]  alu_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic             memrw_i,
  input  logic             memrd_i,
  input  logic             regwen_i,
  output logic             regwe_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             err_o,
  output logic [1:0]       err_code_o
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   mdr_q, mdr_d;
  logic [XLEN-1:0]   daddr_q, daddr_d;
  logic [XLEN-1:0]   dwdata_q, dwdata_d;
  logic              dwe_q, dwe_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              err_q, err_d;
  err_e              code_q, code_d;

  logic if_done, if_to;
  logic dm_done, dm_to;

  rv_mem_port #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_iport (
    .clk       (clk),
    .rst_n     (rst_n),
    .active_i  (state_q == FETCH),
    .ack_i     (imem_ack),
    .req_o     (imem_req),
    .done_o    (if_done),
    .timeout_o (if_to)
  );

  rv_mem_port #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_dport (
    .clk       (clk),
    .rst_n     (rst_n),
    .active_i  (state_q == MEM),
    .ack_i     (dmem_ack),
    .req_o     (dmem_req),
    .done_o    (dm_done),
    .timeout_o (dm_to)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    daddr_d   = daddr_q;
    dwdata_d  = dwdata_q;
    dwe_d     = dwe_q;
    instret_d = instret_q;
    err_d     = err_q;
    code_d    = code_q;
    regwe_o   = 1'b0;
    unique case (state_q)
      RST: state_d = FETCH;
      FETCH: begin
        if (if_done) begin
          ir_d    = imem_rdata;
          state_d = EXEC;
        end else if (if_to) begin
          err_d   = 1'b1;
          code_d  = ERR_IMEM_TO;
          state_d = TRAP;
        end
      end
      EXEC: begin
        if (memrw_i || memrd_i) begin
          daddr_d  = alu_i;
          dwdata_d = rs2_i;
          dwe_d    = memrw_i;
          state_d  = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (dm_done) begin
          if (!dwe_q) mdr_d = dmem_rdata;
          dwe_d   = 1'b0;
          state_d = WB;
        end else if (dm_to) begin
          dwe_d   = 1'b0;
          err_d   = 1'b1;
          code_d  = ERR_DMEM_TO;
          state_d = TRAP;
        end
      end
      WB: begin
        regwe_o = regwen_i;
        if (npc_i[1:0] != 2'b00) begin
          err_d   = 1'b1;
          code_d  = ERR_MISALIGN;
          state_d = TRAP;
        end else begin
          pc_d      = npc_i;
          instret_d = instret_q + 1'b1;
          state_d   = FETCH;
        end
      end
      TRAP: state_d = TRAP;
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST;
      pc_q      <= RESET_PC;
      ir_q      <= NOP;
      mdr_q     <= '0;
      daddr_q   <= '0;
      dwdata_q  <= '0;
      dwe_q     <= 1'b0;
      instret_q <= '0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      daddr_q   <= daddr_d;
      dwdata_q  <= dwdata_d;
      dwe_q     <= dwe_d;
      instret_q <= instret_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign mdr_o      = mdr_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign dmem_we    = dwe_q;
  assign instret_o  = instret_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_rv_mc_seq.sv
// Directed bench for rv_mc_seq with a per-instruction scoreboard.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_rv_mc_seq;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc_o, ir_o, mdr_o;
  logic [31:0] npc_i, alu_i, rs2_i;
  logic        memrw_i, memrd_i, regwen_i;
  logic        regwe_o, err_o;
  logic [31:0] instret_o;
  logic [1:0]  err_code_o;

  rv_mc_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .pc_o       (pc_o),
    .ir_o       (ir_o),
    .mdr_o      (mdr_o),
    .npc_i      (npc_i),
    .alu_i      (alu_i),
    .rs2_i      (rs2_i),
    .memrw_i    (memrw_i),
    .memrd_i    (memrd_i),
    .regwen_i   (regwen_i),
    .regwe_o    (regwe_o),
    .instret_o  (instret_o),
    .err_o      (err_o),
    .err_code_o (err_code_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int regwe_cnt = 0;
  logic [31:0] pc_m, instret_m, mem_100;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] instret;
    int          regwe;
    logic        chk_mdr;
    logic [31:0] mdr;
    logic        trap;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) if (regwe_o === 1'b1) regwe_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    imem_ack = 0; imem_rdata = 0;
    dmem_ack = 0; dmem_rdata = 0;
    npc_i = 0; alu_i = 0; rs2_i = 0;
    memrw_i = 0; memrd_i = 0; regwen_i = 0;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_pc"}, pc_o, 32'h0);
    chk({tag, "_ir"}, ir_o, NOP_W);
    chk({tag, "_mdr"}, mdr_o, 32'h0);
    chk({tag, "_ireq"}, imem_req, 1'b0);
    chk({tag, "_dreq"}, dmem_req, 1'b0);
    chk({tag, "_dwe"}, dmem_we, 1'b0);
    chk({tag, "_daddr"}, dmem_addr, 32'h0);
    chk({tag, "_dwdata"}, dmem_wdata, 32'h0);
    chk({tag, "_instret"}, instret_o, 32'h0);
    chk({tag, "_err"}, err_o, 1'b0);
    chk({tag, "_code"}, err_code_o, 2'b00);
    chk({tag, "_regwe"}, regwe_o, 1'b0);
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 0;
    #1;
    reset_vals("rst");
    step();
    rst_n = 1;
    pc_m = 0;
    instret_m = 0;
  endtask

  task automatic wait_ifetch();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("ifetch_wait", n < 20, 1'b1);
  endtask

  task automatic run_instr(
    input logic [31:0] instr, input int iw,
    input logic st, input logic ld, input logic rwen,
    input logic [31:0] npc, input logic [31:0] alu,
    input logic [31:0] rs2, input logic [31:0] rd,
    input int mw, input logic trap);
    exp_t e;
    memrw_i = st; memrd_i = ld; regwen_i = rwen;
    npc_i = npc; alu_i = alu; rs2_i = rs2;
    e.pc = trap ? pc_m : npc;
    e.ir = instr;
    e.instret = trap ? instret_m : instret_m + 1;
    e.regwe = rwen ? 1 : 0;
    e.chk_mdr = ld;
    e.mdr = rd;
    e.trap = trap;
    sb.push_back(e);
    wait_ifetch();
    regwe_cnt = 0;
    chk("imem_addr", imem_addr, pc_m);
    repeat (iw) step();
    chk("imem_req_held", imem_req, 1'b1);
    imem_ack = 1; imem_rdata = instr;
    step();
    imem_ack = 0; imem_rdata = 0;
    chk("exec_ireq", imem_req, 1'b0);
    step();
    if (st || ld) begin
      chk("mem_req", dmem_req, 1'b1);
      chk("mem_addr", dmem_addr, alu);
      chk("mem_we", dmem_we, st);
      if (st) chk("mem_wdata", dmem_wdata, rs2);
      repeat (mw) step();
      chk("mem_req_held", dmem_req, 1'b1);
      dmem_ack = 1; dmem_rdata = rd;
      step();
      dmem_ack = 0; dmem_rdata = 0;
    end else begin
      chk("nomem_dreq", dmem_req, 1'b0);
    end
    chk("regwe_wb", regwe_o, rwen);
    step();
    e = sb.pop_front();
    chk("ir", ir_o, e.ir);
    chk("pc", pc_o, e.pc);
    chk("instret", instret_o, e.instret);
    chk("regwe_cnt", regwe_cnt, e.regwe);
    if (e.chk_mdr) chk("mdr", mdr_o, e.mdr);
    if (e.trap) begin
      chk("trap_err", err_o, 1'b1);
      chk("trap_code", err_code_o, 2'b11);
      chk("trap_ireq", imem_req, 1'b0);
    end else begin
      chk("back_fetch", imem_req, 1'b1);
      chk("no_err", err_o, 1'b0);
      pc_m = npc;
      instret_m = instret_m + 1;
    end
  endtask

  task automatic fetch_to_mem(input logic [31:0] alu,
                              input logic [31:0] rs2);
    memrw_i = 1; memrd_i = 0; regwen_i = 0;
    alu_i = alu; rs2_i = rs2; npc_i = pc_m + 4;
    wait_ifetch();
    imem_ack = 1; imem_rdata = 32'h0020_2023;
    step();
    imem_ack = 0;
    step();
    chk("f2m_dreq", dmem_req, 1'b1);
  endtask

  initial begin
    int n;
    clr_in();
    rst_n = 0;
    step();
    step();
    reset_vals("por");
    rst_n = 1;
    pc_m = 0;
    instret_m = 0;

    run_instr(32'h0050_0093, 0, 0, 0, 1, 32'h4,
              0, 0, 0, 0, 0);
    run_instr(32'h0050_0093, 3, 0, 0, 1, 32'h8,
              0, 0, 0, 0, 0);

    mem_100 = 32'hDEAD_BEEF;
    run_instr(32'h1020_2023, 0, 1, 0, 0, 32'hC,
              32'h100, mem_100, 0, 2, 0);
    run_instr(32'h1000_2183, 1, 0, 1, 1, 32'h10,
              32'h100, 32'h5, mem_100, 2, 0);

    run_instr(32'h0200_0863, 0, 0, 0, 0, 32'h40,
              0, 0, 0, 0, 0);

    dmem_ack = 1; dmem_rdata = 32'h5555_5555;
    run_instr(32'h0010_0113, 2, 0, 0, 1, 32'h44,
              0, 0, 0, 0, 0);
    dmem_ack = 0; dmem_rdata = 0;
    chk("stray_dack_mdr", mdr_o, mem_100);

    run_instr(32'h0010_0113, 15, 0, 0, 1, 32'h48,
              0, 0, 0, 0, 0);

    run_instr(32'h0400_006F, 0, 0, 0, 0, 32'h42,
              0, 0, 0, 0, 1);
    imem_ack = 1; imem_rdata = 32'hFFFF_FFFF;
    repeat (3) step();
    imem_ack = 0;
    chk("trap_ir_hold", ir_o, 32'h0400_006F);
    chk("trap_sticky", err_code_o, 2'b11);
    chk("trap_pc_hold", pc_o, 32'h48);

    do_reset();
    wait_ifetch();
    n = 0;
    while (imem_req === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("ito_cycles", n, 16);
    chk("ito_err", err_o, 1'b1);
    chk("ito_code", err_code_o, 2'b01);
    chk("ito_pc", pc_o, 32'h0);
    chk("ito_instret", instret_o, 32'h0);
    repeat (3) step();
    chk("ito_ireq", imem_req, 1'b0);

    do_reset();
    fetch_to_mem(32'h200, 32'h1234_5678);
    n = 0;
    while (dmem_req === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("dto_cycles", n, 16);
    chk("dto_code", err_code_o, 2'b10);
    chk("dto_we", dmem_we, 1'b0);
    chk("dto_instret", instret_o, 32'h0);

    do_reset();
    fetch_to_mem(32'h300, 32'hCAFE_F00D);
    step();
    chk("pre_rst_dreq", dmem_req, 1'b1);
    rst_n = 0;
    #1;
    chk("async_dreq", dmem_req, 1'b0);
    reset_vals("mid_mem");
    step();
    rst_n = 1;
    memrw_i = 0;
    pc_m = 0;
    instret_m = 0;
    step();
    chk("restart_ireq", imem_req, 1'b1);
    chk("restart_addr", imem_addr, 32'h0);
    run_instr(32'h0050_0093, 1, 0, 0, 1, 32'h4,
              0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
